// File: rtl/mem_responder_pkg.sv
// Shared constants for mem_responder.
//   - FSM state encodings (IDLE / WAIT / RESP)
//   - default storage depth and the matching byte-address limit
//   - helper functions for the address limit and the request error check
package mem_responder_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam int unsigned DEPTH_WORDS_DEF = 3072;

   // Word index is always taken from addr[13:2], so depth tops out at 4096 words.
   localparam int unsigned IDX_W = 12;

   localparam logic [31:0] ADDR_LIMIT_DEF = 32'(4 * DEPTH_WORDS_DEF);

   function automatic logic [31:0] addr_limit(input int unsigned depth_words);
      return 32'(4 * depth_words);
   endfunction

   // A request errors when it lies past the end of storage or is not word aligned.
   function automatic logic addr_bad(input logic [31:0] addr, input logic [31:0] limit);
      return (addr >= limit) || (addr[1:0] != 2'b00);
   endfunction

endpackage

// File: rtl/mem_array.sv
// Word-organised storage for mem_responder.
//   clk_i    clock
//   clr_i    synchronous clear of every word (wins over a write)
//   we_i     write strobe
//   be_i     byte-lane enables, bit i -> bits 8i+7:8i
//   waddr_i  write word index
//   wdata_i  lane-aligned write data
//   raddr_i  read word index
//   rdata_o  combinational read data (0 for an index past DEPTH)
module mem_array
   import mem_responder_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_WORDS_DEF
) (
   input  logic             clk_i,
   input  logic             clr_i,
   input  logic             we_i,
   input  logic [3:0]       be_i,
   input  logic [IDX_W-1:0] waddr_i,
   input  logic [31:0]      wdata_i,
   input  logic [IDX_W-1:0] raddr_i,
   output logic [31:0]      rdata_o
);

   localparam logic [IDX_W:0] DEPTH_L = (IDX_W + 1)'(DEPTH);

   logic [31:0] mem_q [DEPTH];
   logic        wr_in_range;
   logic        rd_in_range;

   assign wr_in_range = {1'b0, waddr_i} < DEPTH_L;
   assign rd_in_range = {1'b0, raddr_i} < DEPTH_L;

   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i && wr_in_range) begin
         for (int b = 0; b < 4; b++) begin
            if (be_i[b]) begin
               mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
         end
      end
   end

   always_comb begin
      rdata_o = '0;
      if (rd_in_range) begin
         rdata_o = mem_q[raddr_i];
      end
   end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder with fixed response latency.
//   clk, reset                  clock and synchronous active-high reset
//   req_valid / req_ready       request handshake (ready only while idle)
//   req_write, req_addr         store/load select and byte address
//   req_byteen, req_wdata       store lane enables and lane-aligned data
//   rsp_valid / rsp_ready       response handshake, held under backpressure
//   rsp_rdata, rsp_err          load word (0 for stores/errors) and error flag
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int unsigned LATENCY     = 2,
   parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [3:0]  req_byteen,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam logic [31:0] ADDR_LIMIT = addr_limit(DEPTH_WORDS);
   localparam logic [3:0]  LAT_INIT   = 4'(LATENCY - 1);

   logic [1:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic        write_q;
   logic [31:0] addr_q;
   logic [3:0]  byteen_q;
   logic [31:0] wdata_q;

   logic        accept;
   logic        enter_resp;

   logic        cur_write;
   logic [31:0] cur_addr;
   logic [3:0]  cur_byteen;
   logic [31:0] cur_wdata;
   logic        cur_err;
   logic [31:0] mem_rdata;

   // With LATENCY=1 the commit edge is the accept edge itself, so the request
   // has to come straight from the inputs rather than the latched copy.
   always_comb begin
      if (state_q == ST_IDLE) begin
         cur_write  = req_write;
         cur_addr   = req_addr;
         cur_byteen = req_byteen;
         cur_wdata  = req_wdata;
      end else begin
         cur_write  = write_q;
         cur_addr   = addr_q;
         cur_byteen = byteen_q;
         cur_wdata  = wdata_q;
      end
      cur_err = addr_bad(cur_addr, ADDR_LIMIT);
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rdata_d    = rdata_q;
      err_d      = err_q;
      accept     = 1'b0;
      enter_resp = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               accept = 1'b1;
               if (LATENCY == 1) begin
                  state_d    = ST_RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = LAT_INIT;
               end
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d    = ST_RESP;
               enter_resp = 1'b1;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Response data is captured once on RESP entry and then held.
      if (enter_resp) begin
         err_d   = cur_err;
         rdata_d = (cur_write || cur_err) ? 32'd0 : mem_rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         write_q  <= req_write;
         addr_q   <= req_addr;
         byteen_q <= req_byteen;
         wdata_q  <= req_wdata;
      end
   end

   mem_array #(
      .DEPTH (DEPTH_WORDS)
   ) u_mem_array (
      .clk_i   (clk),
      .clr_i   (reset),
      .we_i    (enter_resp && cur_write && !cur_err),
      .be_i    (cur_byteen),
      .waddr_i (cur_addr[13:2]),
      .wdata_i (cur_wdata),
      .raddr_i (cur_addr[13:2]),
      .rdata_o (mem_rdata)
   );

   assign req_ready = (state_q == ST_IDLE);
   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a LATENCY=2 instance checked every cycle against a
// transaction-level model, plus a LATENCY=1 instance driven back-to-back.
module tb_mem_responder;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   int          tb_cyc = 0;
   int          checks = 0;
   int          errors = 0;

   // LATENCY=2 instance
   logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic [3:0]  req_byteen = '0;
   logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
   logic [31:0] rsp_rdata;

   // LATENCY=1 instance
   logic        req_valid1 = 1'b0, req_ready1, req_write1 = 1'b0;
   logic [31:0] req_addr1 = '0, req_wdata1 = '0;
   logic [3:0]  req_byteen1 = '0;
   logic        rsp_valid1, rsp_err1;
   logic        rsp_ready1 = 1'b1;
   logic [31:0] rsp_rdata1;

   int          acc_cyc;

   always #5 clk = ~clk;
   always @(posedge clk) tb_cyc <= tb_cyc + 1;

   mem_responder #(.LATENCY(2)) dut2 (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_addr(req_addr), .req_byteen(req_byteen),
      .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   mem_responder #(.LATENCY(1)) dut1 (
      .clk(clk), .reset(reset), .req_valid(req_valid1), .req_ready(req_ready1),
      .req_write(req_write1), .req_addr(req_addr1), .req_byteen(req_byteen1),
      .req_wdata(req_wdata1), .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
      .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, tb_cyc, got, exp);
      end
   endtask

   // Transaction model for dut2: a word array, one pending response, and the
   // cycle it was accepted in. Response content is fixed at accept time, which
   // is equivalent because nothing else can touch memory while it is pending.
   logic [31:0] mmem [3072];
   bit          m_busy = 0;
   int          m_acc = 0;
   logic [31:0] m_rd = '0;
   logic        m_err = 1'b0;

   initial begin
      forever begin
         @(negedge clk);
         begin
            bit exp_valid;
            exp_valid = m_busy && (tb_cyc - m_acc >= 2);
            chk("model req_ready", 32'(req_ready), 32'(!m_busy));
            chk("model rsp_valid", 32'(rsp_valid), 32'(exp_valid));
            if (exp_valid) begin
               chk("model rsp_rdata", rsp_rdata, m_rd);
               chk("model rsp_err", 32'(rsp_err), 32'(m_err));
            end
            if (exp_valid && rsp_ready) begin
               m_busy = 0;
            end else if (!m_busy && req_valid) begin
               m_busy = 1;
               m_acc  = tb_cyc;
               m_err  = (req_addr >= 32'h3000) || (req_addr[1:0] != 2'b00);
               m_rd   = '0;
               if (!m_err && req_write) begin
                  for (int b = 0; b < 4; b++) begin
                     if (req_byteen[b]) mmem[req_addr >> 2][8*b +: 8] = req_wdata[8*b +: 8];
                  end
               end else if (!m_err) begin
                  m_rd = mmem[req_addr >> 2];
               end
            end
            if (reset) begin
               m_busy = 0;
               for (int i = 0; i < 3072; i++) mmem[i] = '0;
            end
         end
      end
   end

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic issue(input logic wr, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wd);
      int n;
      req_write  = wr;
      req_addr   = addr;
      req_byteen = be;
      req_wdata  = wd;
      req_valid  = 1'b1;
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) chk("accept timeout", 32'(req_ready), 32'd1);
      acc_cyc = tb_cyc;
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic wait_rsp(input int hold, input bit pulse, output logic [31:0] rd,
                           output logic er, output int lat);
      int n;
      n = 0;
      rd = '0;
      er = 1'b0;
      lat = -1;
      @(negedge clk);
      while (!rsp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!rsp_valid) begin
         chk("response timeout", 32'(rsp_valid), 32'd1);
         return;
      end
      lat = tb_cyc - acc_cyc;
      rd  = rsp_rdata;
      er  = rsp_err;
      for (int k = 0; k < hold; k++) begin
         @(posedge clk);
         #1;
         if (pulse) begin
            req_valid  = 1'b1;
            req_write  = 1'b1;
            req_addr   = 32'h10;
            req_byteen = 4'hF;
            req_wdata  = 32'h0;
         end
         @(negedge clk);
         chk("hold rsp_valid", 32'(rsp_valid), 32'd1);
         chk("hold rsp_rdata", rsp_rdata, rd);
         chk("hold req_ready", 32'(req_ready), 32'd0);
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
   endtask

   task automatic xact(input logic wr, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wd, input string name,
                       input logic [31:0] exp_rd, input logic exp_er);
      logic [31:0] rd;
      logic        er;
      int          lat;
      issue(wr, addr, be, wd);
      wait_rsp(0, 1'b0, rd, er, lat);
      chk({name, " latency"}, 32'(lat), 32'd2);
      chk({name, " rdata"}, rd, exp_rd);
      chk({name, " err"}, 32'(er), 32'(exp_er));
   endtask

   // Back-to-back stream for the LATENCY=1 instance.
   logic        v_wr [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
   logic [31:0] v_ad [6] = '{32'h100, 32'h100, 32'h104, 32'h104, 32'h100, 32'h100};
   logic [3:0]  v_be [6] = '{4'hF, 4'h0, 4'hF, 4'h0, 4'h3, 4'h0};
   logic [31:0] v_wd [6] = '{32'hA5A5_0001, 32'h0, 32'h0BAD_CAFE, 32'h0, 32'h7777_1234, 32'h0};
   logic [31:0] v_rd [6] = '{32'h0, 32'hA5A5_0001, 32'h0, 32'h0BAD_CAFE, 32'h0, 32'hA5A5_1234};

   task automatic run_lat1();
      int idx = 0, nrsp = 0, last_acc = -1, last_idx = 0;
      bit acc;
      req_write1 = v_wr[0]; req_addr1 = v_ad[0]; req_byteen1 = v_be[0]; req_wdata1 = v_wd[0];
      req_valid1 = 1'b1;
      for (int c = 0; c < 40 && nrsp < 6; c++) begin
         @(negedge clk);
         acc = 0;
         if (rsp_valid1) begin
            chk("lat1 rsp one cycle after accept", 32'(tb_cyc - last_acc), 32'd1);
            chk("lat1 rdata", rsp_rdata1, v_rd[last_idx]);
            chk("lat1 err", 32'(rsp_err1), 32'd0);
            nrsp++;
         end
         if (req_valid1 && req_ready1) begin
            if (last_acc >= 0) chk("lat1 accept spacing", 32'(tb_cyc - last_acc), 32'd2);
            last_acc = tb_cyc;
            last_idx = idx;
            acc = 1;
         end
         @(posedge clk);
         #1;
         if (acc) begin
            idx++;
            if (idx < 6) begin
               req_write1 = v_wr[idx]; req_addr1 = v_ad[idx];
               req_byteen1 = v_be[idx]; req_wdata1 = v_wd[idx];
            end else begin
               req_valid1 = 1'b0;
            end
         end
      end
      chk("lat1 response count", 32'(nrsp), 32'd6);
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat;

      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("reset req_ready", 32'(req_ready), 32'd1);
      chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
      @(posedge clk);
      #1;

      // Full-word store then load back.
      xact(1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, "store 0x10", 32'h0, 1'b0);
      xact(1'b0, 32'h10, 4'h0, 32'h0, "load 0x10", 32'hDEAD_BEEF, 1'b0);

      // Byte-lane merge.
      xact(1'b1, 32'h20, 4'hF, 32'h1122_3344, "store 0x20", 32'h0, 1'b0);
      xact(1'b1, 32'h20, 4'h5, 32'hAABB_CCDD, "merge 0x20", 32'h0, 1'b0);
      xact(1'b0, 32'h20, 4'hF, 32'h0, "load 0x20", 32'h11BB_33DD, 1'b0);

      // Range and alignment errors; last legal word.
      xact(1'b0, 32'h3000, 4'h0, 32'h0, "load 0x3000", 32'h0, 1'b1);
      xact(1'b0, 32'h0002, 4'h0, 32'h0, "load 0x0002", 32'h0, 1'b1);
      xact(1'b1, 32'h3000, 4'hF, 32'hFFFF_FFFF, "store 0x3000", 32'h0, 1'b1);
      xact(1'b1, 32'h2FFC, 4'hF, 32'hCAFE_F00D, "store 0x2FFC", 32'h0, 1'b0);
      xact(1'b0, 32'h2FFC, 4'h0, 32'h0, "load 0x2FFC", 32'hCAFE_F00D, 1'b0);
      xact(1'b0, 32'h0000, 4'h0, 32'h0, "load 0x0 untouched", 32'h0, 1'b0);
      xact(1'b0, 32'h10, 4'h0, 32'h0, "load 0x10 after err", 32'hDEAD_BEEF, 1'b0);

      // Empty byte-enable store is a clean no-op.
      xact(1'b1, 32'h10, 4'h0, 32'h5555_5555, "store be0", 32'h0, 1'b0);
      xact(1'b0, 32'h10, 4'h0, 32'h0, "load after be0", 32'hDEAD_BEEF, 1'b0);

      // Backpressure with a stray request pulsed meanwhile.
      issue(1'b0, 32'h20, 4'h0, 32'h0);
      wait_rsp(5, 1'b1, rd, er, lat);
      chk("bp latency", 32'(lat), 32'd2);
      chk("bp rdata", rd, 32'h11BB_33DD);
      xact(1'b0, 32'h10, 4'h0, 32'h0, "load after bp", 32'hDEAD_BEEF, 1'b0);

      // Reset while a store waits: nothing comes back, nothing is written.
      issue(1'b1, 32'h40, 4'hF, 32'h1234_5678);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("post-reset rsp_valid", 32'(rsp_valid), 32'd0);
      end
      @(posedge clk);
      #1;
      xact(1'b0, 32'h40, 4'h0, 32'h0, "load 0x40 after reset", 32'h0, 1'b0);

      run_lat1();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter LATENCY, default 2, cycles from request acceptance to rsp_valid; legal range 1..15.
REQ-002 Parameter DEPTH_WORDS, default 3072, number of 32-bit words (byte range 0x0000_0000..0x0000_2FFF).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_byteen  input  4  store byte enables; bit i writes byte lane i (bits 8i+7:8i).
REQ-010 req_wdata  input  32  store data, already lane-aligned.
REQ-011 rsp_valid  output  1  response present.
REQ-012 rsp_ready  input  1  initiator accepts the response.
REQ-013 rsp_rdata  output  32  load data (full word); 0 for stores and errors.
REQ-014 rsp_err  output  1  request was out of range or misaligned.

Function
REQ-015 FSM states: IDLE, WAIT, RESP; one outstanding request maximum.
REQ-016 IDLE: req_ready=1, rsp_valid=0; on req_valid the request is accepted and all request fields are latched.
REQ-017 Accept at edge T moves to WAIT holding a counter at LATENCY-1, or directly to RESP when LATENCY=1.
REQ-018 WAIT: req_ready=0, rsp_valid=0; counter decrements each cycle; on the edge where it is 1, the state moves to RESP.
REQ-019 rsp_valid rises exactly LATENCY cycles after the accepting edge.
REQ-020 Stores commit, and loads sample memory, on the edge that enters RESP; loads therefore observe all previously acknowledged stores.
REQ-021 RESP: rsp_valid=1, req_ready=0; rsp_rdata and rsp_err are held stable until rsp_ready=1, and the handshake edge returns the state to IDLE.
REQ-022 A new request can be accepted no earlier than the cycle after the response handshake; sustained throughput is one request per LATENCY+1 cycles at best.
REQ-023 Word index = req_addr[13:2].
REQ-024 rsp_err=1 when req_addr >= 4*DEPTH_WORDS or req_addr[1:0] != 0.
REQ-025 An erroring request writes nothing and returns rsp_rdata=0, but completes the normal handshake and latency.
REQ-026 Store merge: only lanes with byteen=1 change; byteen=4'b0000 is a legal no-op store with rsp_err=0.
REQ-027 Loads ignore req_byteen and return the whole word; lane extraction and extension are the initiator's job.
REQ-028 rsp_valid stays high indefinitely while rsp_ready=0 (backpressure); the FSM never drops or overwrites a pending response.
REQ-029 req_valid while not in IDLE is ignored; the initiator must hold the request until it sees req_ready.

Reset
REQ-030 While reset=1, on each edge: state=IDLE, counter=0, all memory words=0, rsp_rdata=0, rsp_err=0.
REQ-031 Outputs during and after reset: req_ready=1, rsp_valid=0.
REQ-032 Reset asserted mid-operation (WAIT or RESP) abandons the request: no store commits and no response is produced.

Structure
REQ-033 The shared constants file holds the FSM state encodings, DEPTH_WORDS default, and the address-limit constant.
REQ-034 One sub-module, mem_array: the DEPTH_WORDS x 32 storage with a byte-enabled synchronous write port, a read port, and synchronous clear; the FSM, counter and address checking stay in mem_responder.

Verification
REQ-035 LATENCY=2; store addr 0x10, byteen 1111, data 0xDEADBEEF, then load 0x10 -> each rsp_valid exactly 2 cycles after accept; the load returns 0xDEADBEEF with rsp_err=0.
REQ-036 Word 0x20 = 0x11223344; store byteen 0101, data 0xAABBCCDD; load 0x20 -> returns 0x11BB33DD.
REQ-037 Load 0x3000, then load 0x0002 -> both give rsp_err=1 and rsp_rdata=0; a store to 0x3000 leaves every word unchanged.
REQ-038 Hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stay stable and req_ready=0; req_valid pulsed meanwhile is not accepted.
REQ-039 Store accepted, then reset asserted during WAIT -> no response; a subsequent load of that address returns 0.
REQ-040 LATENCY=1 with back-to-back requests and rsp_ready tied to 1 -> accepts occur every 2 cycles and rsp_valid asserts 1 cycle after each accept.
